// File: rtl/pe_loader_seq.sv
// -----------------------------------------------------------------------------
// pe_loader_seq
//
// Sequencer that feeds one processing element (PE) for a dot-product style job.
// A job of `len` elements runs in two phases over one operand stream:
//   1. LOAD  : the first `len` stream words (operand B) are written into the
//              PE local RAM at addresses 0..len-1.
//   2. MAC   : the PE accumulator is cleared once, then for every element the
//              RAM address is presented (one cycle for the PE's registered RAM
//              read), the next stream word (operand A) is issued with
//              pe_valid, and the sequencer waits for pe_dvalid before it
//              moves on. Only one MAC is ever in flight because the PE
//              accumulator feedback is only up to date after pe_dvalid.
// The last captured pe_dout is presented on `result`. A missing pe_dvalid for
// TIMEOUT cycles, or a len larger than the RAM, ends the job with err set.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   start, len          job request; len sampled when start is seen in IDLE
//   s_tdata/s_tvalid/s_tready  operand stream (len B words, then len A words)
//   pe_aresetn          active-low PE accumulator clear (one cycle per job)
//   pe_din/pe_addr/pe_we       PE RAM write port / shared RAM address
//   pe_ain/pe_valid     MAC operand and issue strobe
//   pe_dvalid/pe_dout   MAC result from the PE
//   result              last captured MAC result
//   done                one-cycle end-of-job pulse
//   busy                high whenever a job is in progress
//   err                 sticky error flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module pe_loader_seq #(
  parameter int L_RAM_SIZE = 6,
  parameter int TIMEOUT    = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  pe_aresetn,
  output logic [31:0]           pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [31:0]           pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout,
  output logic [31:0]           result,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  // Largest legal len is the full RAM depth, which needs the extra len bit.
  localparam logic [L_RAM_SIZE:0] DEPTH   = {1'b1, {L_RAM_SIZE{1'b0}}};
  localparam logic [L_RAM_SIZE:0] IDX_ONE = {{L_RAM_SIZE{1'b0}}, 1'b1};

  // Wait-cycle counter wide enough to hold TIMEOUT-1.
  localparam int                CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]     TMO_ONE  = CW'(1);
  localparam logic [CW-1:0]     TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_ADDR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [L_RAM_SIZE:0]     len_q, len_d;
  logic [L_RAM_SIZE:0]     idx_q, idx_d;
  logic [CW-1:0]           tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [31:0]             result_q, result_d;
  logic [31:0]             pe_din_q, pe_din_d;
  logic [L_RAM_SIZE-1:0]   pe_addr_q, pe_addr_d;
  logic [31:0]             pe_ain_q, pe_ain_d;
  logic                    pe_we_q, pe_we_d;
  logic                    pe_valid_q, pe_valid_d;
  logic                    pe_aresetn_q, pe_aresetn_d;

  logic [L_RAM_SIZE:0]     idx_inc;
  logic                    last_elem;

  assign idx_inc   = idx_q + IDX_ONE;
  assign last_elem = (idx_inc == len_q);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    result_d     = result_q;
    pe_din_d     = pe_din_q;
    pe_addr_d    = pe_addr_q;
    pe_ain_d     = pe_ain_q;
    // Strobes default low so they only ever last the single cycle after
    // the handshake that produced them.
    pe_we_d      = 1'b0;
    pe_valid_d   = 1'b0;
    pe_aresetn_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len;
          idx_d = '0;
          err_d = 1'b0;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (len > DEPTH) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (s_tvalid) begin
          pe_din_d  = s_tdata;
          pe_addr_d = idx_q[L_RAM_SIZE-1:0];
          pe_we_d   = 1'b1;
          if (last_elem) begin
            idx_d        = '0;
            state_d      = S_CLEAR;
            // Registered so the clear is low exactly while in CLEAR.
            pe_aresetn_d = 1'b0;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      S_CLEAR: begin
        // Present element 0's address so ADDR covers the RAM read latency.
        pe_addr_d = idx_q[L_RAM_SIZE-1:0];
        state_d   = S_ADDR;
      end

      S_ADDR: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (s_tvalid) begin
          pe_ain_d   = s_tdata;
          pe_valid_d = 1'b1;
          tmo_d      = '0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // A result arriving on the same cycle as the timeout wins.
        if (pe_dvalid) begin
          result_d = pe_dout;
          idx_d    = idx_inc;
          tmo_d    = '0;
          if (last_elem) begin
            state_d = S_DONE;
          end else begin
            pe_addr_d = idx_inc[L_RAM_SIZE-1:0];
            state_d   = S_ADDR;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      result_q     <= '0;
      pe_din_q     <= '0;
      pe_addr_q    <= '0;
      pe_ain_q     <= '0;
      pe_we_q      <= 1'b0;
      pe_valid_q   <= 1'b0;
      // The PE is held cleared for as long as the sequencer is in reset.
      pe_aresetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      result_q     <= result_d;
      pe_din_q     <= pe_din_d;
      pe_addr_q    <= pe_addr_d;
      pe_ain_q     <= pe_ain_d;
      pe_we_q      <= pe_we_d;
      pe_valid_q   <= pe_valid_d;
      pe_aresetn_q <= pe_aresetn_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The stream is only accepted while a word is actually wanted, so beats
  // beyond 2*len stay in the upstream source.
  assign s_tready   = (state_q == S_LOAD) || (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign result     = result_q;
  assign pe_din     = pe_din_q;
  assign pe_addr    = pe_addr_q;
  assign pe_we      = pe_we_q;
  assign pe_ain     = pe_ain_q;
  assign pe_valid   = pe_valid_q;
  assign pe_aresetn = pe_aresetn_q;

endmodule
